// File: rtl/bel_cbfly_pipe.sv
// rtl/bel_cbfly_pipe.sv - pipelined complex radix-2 butterfly with scaling, saturation and valid/ready flow control
module bel_cbfly_pipe #(
    parameter int word_width = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [word_width-1:0] a_re_i,
    input  logic [word_width-1:0] a_im_i,
    input  logic [word_width-1:0] b_re_i,
    input  logic [word_width-1:0] b_im_i,
    input  logic                  scale_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [word_width-1:0] sum_re_o,
    output logic [word_width-1:0] sum_im_o,
    output logic [word_width-1:0] dif_re_o,
    output logic [word_width-1:0] dif_im_o,
    output logic                  ovf_o,
    output logic                  ovf_sticky_o,
    input  logic                  ovf_clr_i
);

    localparam int RW = word_width + 1;

    logic                 s1_valid;
    logic                 s1_scale;
    logic signed [RW-1:0] s1_r [4];
    logic                 s2_valid;
    logic [word_width-1:0] s2_d [4];
    logic                 s2_ovf;
    logic                 sticky;

    logic                  s1_adv;
    logic                  s2_adv;
    logic [word_width-1:0] red_val [4];
    logic [3:0]            red_ovf;

    // Returns {ovf, value}. Halving never overflows; full scale clamps when the two top bits disagree.
    function automatic logic [word_width:0] reduce(input logic signed [RW-1:0] r, input logic scale);
        if (scale)
            return {1'b0, word_width'((r + 32'sd1) >>> 1)};
        if (r[RW-1] != r[word_width-1])
            return {1'b1, r[RW-1], {(word_width-1){~r[RW-1]}}};
        return {1'b0, r[word_width-1:0]};
    endfunction

    assign s2_adv     = !s2_valid || out_ready_i;
    assign s1_adv     = !s1_valid || s2_adv;
    assign in_ready_o = s1_adv;

    always_comb begin
        for (int i = 0; i < 4; i++)
            {red_ovf[i], red_val[i]} = reduce(s1_r[i], s1_scale);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s2_valid <= 1'b0;
            s2_ovf   <= 1'b0;
            sticky   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s1_r[i] <= '0;
                s2_d[i] <= '0;
            end
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid_i;
                if (in_valid_i) begin
                    s1_scale <= scale_i;
                    s1_r[0]  <= {a_re_i[word_width-1], a_re_i} + {b_re_i[word_width-1], b_re_i};
                    s1_r[1]  <= {a_im_i[word_width-1], a_im_i} + {b_im_i[word_width-1], b_im_i};
                    s1_r[2]  <= {a_re_i[word_width-1], a_re_i} - {b_re_i[word_width-1], b_re_i};
                    s1_r[3]  <= {a_im_i[word_width-1], a_im_i} - {b_im_i[word_width-1], b_im_i};
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_ovf <= |red_ovf;
                    for (int i = 0; i < 4; i++)
                        s2_d[i] <= red_val[i];
                end
            end
            // Set has priority over clear on the same edge.
            if (s2_adv && s1_valid && |red_ovf)
                sticky <= 1'b1;
            else if (ovf_clr_i)
                sticky <= 1'b0;
        end
    end

    assign out_valid_o  = s2_valid;
    assign sum_re_o     = s2_d[0];
    assign sum_im_o     = s2_d[1];
    assign dif_re_o     = s2_d[2];
    assign dif_im_o     = s2_d[3];
    assign ovf_o        = s2_ovf;
    assign ovf_sticky_o = sticky;

endmodule

// File: tb/tb_bel_cbfly_pipe.sv
// tb/tb_bel_cbfly_pipe.sv - scoreboard bench for bel_cbfly_pipe
module tb_bel_cbfly_pipe;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] a_re_i = '0, a_im_i = '0, b_re_i = '0, b_im_i = '0;
    logic         scale_i = 1'b0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] sum_re_o, sum_im_o, dif_re_o, dif_im_o;
    logic         ovf_o;
    logic         ovf_sticky_o;
    logic         ovf_clr_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int npop = 0;

    logic [64:0] sb [$];
    logic        prev_stall = 1'b0;
    logic [65:0] hold_val = '0;

    bel_cbfly_pipe #(.word_width(W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_re_i(a_re_i), .a_im_i(a_im_i), .b_re_i(b_re_i), .b_im_i(b_im_i),
        .scale_i(scale_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sum_re_o(sum_re_o), .sum_im_o(sum_im_o), .dif_re_o(dif_re_o), .dif_im_o(dif_im_o),
        .ovf_o(ovf_o), .ovf_sticky_o(ovf_sticky_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model_red(input int r, input bit sc);
        int v;
        bit o;
        o = 1'b0;
        if (sc) v = (r + 1) >>> 1;
        else if (r > 32767) begin v = 32767; o = 1'b1; end
        else if (r < -32768) begin v = -32768; o = 1'b1; end
        else v = r;
        return {o, v[15:0]};
    endfunction

    function automatic logic [64:0] model(input int ar, ai, br, bi, input bit sc);
        logic [16:0] r0, r1, r2, r3;
        r0 = model_red(ar + br, sc);
        r1 = model_red(ai + bi, sc);
        r2 = model_red(ar - br, sc);
        r3 = model_red(ai - bi, sc);
        return {r0[16] | r1[16] | r2[16] | r3[16], r0[15:0], r1[15:0], r2[15:0], r3[15:0]};
    endfunction

    // Scoreboard: push on input acceptance, pop and compare on output transfer.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_ready_o, !(sb.size() == 2 && !out_ready_i));
            if (prev_stall)
                chk("hold_stall", {out_valid_o, ovf_o, sum_re_o, sum_im_o, dif_re_o, dif_im_o}, hold_val);
            if (out_valid_o && out_ready_i) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0)
                    chk("out_data", {ovf_o, sum_re_o, sum_im_o, dif_re_o, dif_im_o}, sb.pop_front());
                npop++;
            end
            if (in_valid_i && in_ready_o)
                sb.push_back(model($signed(a_re_i), $signed(a_im_i), $signed(b_re_i), $signed(b_im_i), scale_i));
            prev_stall = out_valid_o && !out_ready_i;
            hold_val = {out_valid_o, ovf_o, sum_re_o, sum_im_o, dif_re_o, dif_im_o};
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int ar, ai, br, bi, input bit sc, input bit v);
        a_re_i = ar[15:0];
        a_im_i = ai[15:0];
        b_re_i = br[15:0];
        b_im_i = bi[15:0];
        scale_i = sc;
        in_valid_i = v;
    endtask

    task automatic idle;
        in_valid_i = 1'b0;
    endtask

    initial begin
        int idx;
        int np0;
        bit acc;
        bit iv [16];
        int vals [8][4];
        bit scs [8];

        tick;
        tick;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_sticky", ovf_sticky_o, 0);
        chk("rst_data", {ovf_o, sum_re_o, sum_im_o, dif_re_o, dif_im_o}, 0);
        rst_n_i = 1'b1;
        tick;
        chk("rst_in_ready", in_ready_o, 1);

        // Basic full-scale butterfly and two-cycle latency
        out_ready_i = 1'b1;
        drive(1000, -2000, 300, 500, 0, 1);
        tick;
        idle;
        chk("lat_s1", out_valid_o, 0);
        tick;
        chk("lat_s2", out_valid_o, 1);
        chk("basic_sum", {sum_re_o, sum_im_o}, {16'd1300, 16'hFA24});
        chk("basic_dif", {dif_re_o, dif_im_o, ovf_o}, {16'd700, 16'hF63C, 1'b0});
        tick;

        // Saturation, sticky set then clear
        drive(32767, -32768, 1, 1, 0, 1);
        tick;
        idle;
        tick;
        chk("sat_vals", {sum_re_o, sum_im_o, dif_re_o, dif_im_o}, {16'h7FFF, 16'h8001, 16'h7FFE, 16'h8000});
        chk("sat_ovf", ovf_o, 1);
        chk("sat_sticky", ovf_sticky_o, 1);
        ovf_clr_i = 1'b1;
        tick;
        ovf_clr_i = 1'b0;
        chk("sticky_clr", ovf_sticky_o, 0);

        // Set and clear on the same edge: set wins
        drive(32767, -32768, 1, 1, 0, 1);
        tick;
        idle;
        ovf_clr_i = 1'b1;
        tick;
        ovf_clr_i = 1'b0;
        chk("sticky_set_wins", ovf_sticky_o, 1);
        ovf_clr_i = 1'b1;
        tick;
        ovf_clr_i = 1'b0;
        chk("sticky_clr2", ovf_sticky_o, 0);

        // Halving with round-half-up
        drive(3, -3, 0, 0, 1, 1);
        tick;
        drive(32767, -32768, 32767, -32768, 1, 1);
        tick;
        idle;
        chk("scale_a", {sum_re_o, sum_im_o, dif_re_o, dif_im_o}, {16'd2, 16'hFFFF, 16'd2, 16'hFFFF});
        tick;
        chk("scale_b", {ovf_o, sum_re_o, sum_im_o, dif_re_o, dif_im_o}, {1'b0, 16'h7FFF, 16'h8000, 16'd0, 16'd0});
        chk("scale_sticky", ovf_sticky_o, 0);
        tick;

        // Back-pressure: 8 beats against out_ready pattern 1,0,0
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++)
                vals[i][k] = $signed(16'($urandom));
            scs[i] = 1'($urandom_range(0, 1));
        end
        np0 = npop;
        idx = 0;
        for (int cyc = 0; cyc < 80 && idx < 8; cyc++) begin
            out_ready_i = (cyc % 3 == 0);
            drive(vals[idx][0], vals[idx][1], vals[idx][2], vals[idx][3], scs[idx], 1);
            #1;
            acc = in_ready_o;
            tick;
            if (acc) idx++;
        end
        idle;
        chk("bp_accepted", idx, 8);
        out_ready_i = 1'b1;
        repeat (5) tick;
        chk("bp_delivered", npop - np0, 8);

        // Bubbles: out_valid follows in_valid two cycles later
        for (int j = 0; j < 16; j++)
            iv[j] = (j < 8) && (j % 2 == 0);
        for (int j = 0; j < 12; j++) begin
            if (j >= 2)
                chk("bubble_valid", out_valid_o, iv[j-2]);
            drive(j * 100, -j, j, 7 - j, 0, iv[j]);
            tick;
        end
        idle;

        // Reset while both stages are full and stalled
        out_ready_i = 1'b0;
        drive(32767, 0, 5, 0, 0, 1);
        tick;
        drive(1, 2, 3, 4, 0, 1);
        tick;
        idle;
        chk("full_in_ready", in_ready_o, 0);
        chk("full_sticky", ovf_sticky_o, 1);
        rst_n_i = 1'b0;
        tick;
        rst_n_i = 1'b1;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_sticky", ovf_sticky_o, 0);
        chk("mid_rst_data", {ovf_o, sum_re_o, sum_im_o, dif_re_o, dif_im_o}, 0);
        chk("mid_rst_ready", in_ready_o, 1);
        out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick;
            chk("no_stale", out_valid_o, 0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
